// File: rtl/sar_conv_sequencer.sv
// rtl/sar_conv_sequencer.sv - SAR ADC conversion sequencer with track/hold timing, averaging and timeout
module sar_conv_sequencer #(
    parameter int N_BITS         = 4,
    parameter int MAX_AVG_LOG2   = 3,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont_mode,
    input  logic [3:0]        sample_cycles,
    input  logic [1:0]        avg_log2,
    output logic              sample_en,
    output logic              sar_start,
    input  logic              sar_done,
    input  logic [N_BITS-1:0] sar_code,
    output logic [N_BITS-1:0] result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    localparam int AW    = 2;
    localparam int ACC_W = N_BITS + MAX_AVG_LOG2;
    localparam int NS_W  = MAX_AVG_LOG2 + 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW-1:0] AVG_CLAMP = AW'((MAX_AVG_LOG2 > 3) ? 3 : MAX_AVG_LOG2);
    localparam logic [TW-1:0] T_LIMIT   = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, OUTPUT} state_t;

    state_t              state_q, state_d;
    logic                cont_q, cont_d;
    logic [3:0]          sc_q, sc_d;
    logic [AW-1:0]       avg_q, avg_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                first_q, first_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [NS_W-1:0]     nsamp_q, nsamp_d;
    logic [N_BITS-1:0]   result_q, result_d;
    logic                err_q, err_d;

    logic [ACC_W-1:0]    sum;
    logic [ACC_W-1:0]    half;
    logic [NS_W-1:0]     nsamp_inc;
    logic [NS_W-1:0]     target;

    // The accumulator is sized so that 2^MAX_AVG_LOG2 full-scale codes plus the rounding term never wrap.
    assign sum       = acc_q + ACC_W'(sar_code);
    assign half      = (ACC_W'(1) << avg_q) >> 1;
    assign nsamp_inc = nsamp_q + 1'b1;
    assign target    = NS_W'(1) << avg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cont_q   <= 1'b0;
            sc_q     <= '0;
            avg_q    <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            tcnt_q   <= '0;
            acc_q    <= '0;
            nsamp_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cont_q   <= cont_d;
            sc_q     <= sc_d;
            avg_q    <= avg_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            tcnt_q   <= tcnt_d;
            acc_q    <= acc_d;
            nsamp_q  <= nsamp_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cont_d   = cont_q;
        sc_d     = sc_q;
        avg_d    = avg_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        tcnt_d   = tcnt_q;
        acc_d    = acc_q;
        nsamp_d  = nsamp_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cont_d  = cont_mode;
                    sc_d    = sample_cycles;
                    avg_d   = (avg_log2 > AVG_CLAMP) ? AVG_CLAMP : avg_log2;
                    acc_d   = '0;
                    nsamp_d = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (cnt_q == sc_q) begin
                    first_d = 1'b1;
                    tcnt_d  = '0;
                    state_d = CONVERT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CONVERT: begin
                first_d = 1'b0;
                tcnt_d  = tcnt_q + 1'b1;
                // The sar_start cycle itself never samples sar_done.
                if (!first_q) begin
                    if (sar_done) begin
                        acc_d   = sum;
                        nsamp_d = nsamp_inc;
                        if (nsamp_inc == target) begin
                            result_d = N_BITS'((sum + half) >> avg_q);
                            state_d  = OUTPUT;
                        end else begin
                            cnt_d   = '0;
                            state_d = SAMPLE;
                        end
                    end else if (tcnt_q == T_LIMIT) begin
                        err_d   = 1'b1;
                        acc_d   = '0;
                        nsamp_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    if (cont_q) begin
                        acc_d   = '0;
                        nsamp_d = '0;
                        cnt_d   = '0;
                        state_d = SAMPLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so nothing reaches a pin combinationally from an input.
    always_comb begin
        sample_en = (state_q == SAMPLE);
        sar_start = (state_q == CONVERT) && first_q;
        out_valid = (state_q == OUTPUT);
        busy      = (state_q != IDLE);
        result    = result_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// tb/tb_sar_conv_sequencer.sv - directed self-checking bench for sar_conv_sequencer
module tb_sar_conv_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cont_mode;
    logic [3:0] sample_cycles;
    logic [1:0] avg_log2;
    logic       sample_en;
    logic       sar_start;
    logic       sar_done;
    logic [3:0] sar_code;
    logic [3:0] result;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sar_conv_sequencer #(.N_BITS(4), .MAX_AVG_LOG2(3), .TIMEOUT_CYCLES(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cont_mode     (cont_mode),
        .sample_cycles (sample_cycles),
        .avg_log2      (avg_log2),
        .sample_en     (sample_en),
        .sar_start     (sar_start),
        .sar_done      (sar_done),
        .sar_code      (sar_code),
        .result        (result),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .err           (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [3:0] s, input logic [1:0] a, input logic c);
        sample_cycles = s;
        avg_log2      = a;
        cont_mode     = c;
        start         = 1'b1;
        step();
        start         = 1'b0;
    endtask

    task automatic wait_sar_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sar_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic convert(input logic [3:0] code, input int k);
        for (int i = 0; i < k; i++) step();
        sar_done = 1'b1;
        sar_code = code;
        step();
        sar_done = 1'b0;
    endtask

    task automatic run_samples(input logic [3:0] s, input logic [1:0] a, input logic c,
                               input int n, input logic [31:0] codes, input int k,
                               output int pulses, output bit ok);
        bit got;
        pulses = 0;
        ok     = 1'b1;
        drive_start(s, a, c);
        for (int i = 0; i < n; i++) begin
            wait_sar_start(got);
            if (!got) begin
                ok = 1'b0;
                return;
            end
            pulses++;
            convert(codes[i*4 +: 4], k);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; cont_mode = 1'b0; sample_cycles = '0; avg_log2 = '0;
        sar_done = 1'b0; sar_code = '0; out_ready = 1'b0;
        step();
        step();
        checks++;
        if ({sample_en, sar_start, out_valid, busy, err, result} !== 9'b0) begin
            errors++;
            $display("FAIL reset_held outputs got %b exp 000000000", {sample_en, sar_start, out_valid, busy, err, result});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({sample_en, sar_start, out_valid, busy, err, result} !== 9'b0) begin
            errors++;
            $display("FAIL reset_release outputs got %b exp 000000000", {sample_en, sar_start, out_valid, busy, err, result});
        end
    endtask

    task automatic test_single();
        drive_start(4'd2, 2'd0, 1'b0);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            checks++;
            if ({sample_en, sar_start, out_valid, busy} !== {cyc <= 3, cyc == 4, cyc == 9, 1'b1}) begin
                errors++;
                $display("FAIL single_timing cycle %0d got en/start/valid/busy %b exp %b", cyc,
                         {sample_en, sar_start, out_valid, busy}, {cyc <= 3, cyc == 4, cyc == 9, 1'b1});
            end
            sar_done = (cyc == 8);
            sar_code = 4'hA;
            if (cyc < 9) step();
        end
        checks++;
        if (result !== 4'hA) begin
            errors++;
            $display("FAIL single_result got %h exp a", result);
        end
        handshake();
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_idle valid/busy got %b exp 00", {out_valid, busy});
        end
    endtask

    task automatic test_averaging();
        int p; bit ok;
        run_samples(4'd0, 2'd2, 1'b0, 4, 32'h0000_4443, 2, p, ok);
        checks++;
        if (!ok || p != 4 || out_valid !== 1'b1 || result !== 4'd4) begin
            errors++;
            $display("FAIL avg4_mixed ok=%0d pulses=%0d valid=%b result=%0d exp 1 4 1 4", ok, p, out_valid, result);
        end
        handshake();
        run_samples(4'd1, 2'd2, 1'b0, 4, 32'h0000_FFFF, 3, p, ok);
        checks++;
        if (!ok || p != 4 || out_valid !== 1'b1 || result !== 4'd15) begin
            errors++;
            $display("FAIL avg4_full ok=%0d pulses=%0d valid=%b result=%0d exp 1 4 1 15", ok, p, out_valid, result);
        end
        handshake();
        run_samples(4'd0, 2'd1, 1'b0, 2, 32'h0000_0054, 1, p, ok);
        checks++;
        if (!ok || p != 2 || out_valid !== 1'b1 || result !== 4'd5) begin
            errors++;
            $display("FAIL avg2_round ok=%0d pulses=%0d valid=%b result=%0d exp 1 2 1 5", ok, p, out_valid, result);
        end
        handshake();
    endtask

    task automatic test_clamp_round();
        int p; bit ok;
        run_samples(4'd0, 2'd3, 1'b0, 8, 32'h2111_1111, 1, p, ok);
        checks++;
        if (!ok || p != 8 || out_valid !== 1'b1 || result !== 4'd1) begin
            errors++;
            $display("FAIL avg8_round ok=%0d pulses=%0d valid=%b result=%0d exp 1 8 1 1", ok, p, out_valid, result);
        end
        handshake();
    endtask

    task automatic test_backpressure_cont();
        int p; bit ok; bit got;
        run_samples(4'd1, 2'd0, 1'b1, 1, 32'h0000_0007, 3, p, ok);
        checks++;
        if (!ok || out_valid !== 1'b1 || result !== 4'd7) begin
            errors++;
            $display("FAIL cont_first ok=%0d valid=%b result=%0d exp 1 1 7", ok, out_valid, result);
        end
        sample_cycles = 4'd5; avg_log2 = 2'd2; cont_mode = 1'b0; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({out_valid, sar_start, sample_en, result} !== {3'b100, 4'd7}) begin
                errors++;
                $display("FAIL hold_cycle %0d valid/start/en/result got %b exp 1000111", i, {out_valid, sar_start, sample_en, result});
            end
            step();
        end
        start = 1'b0;
        handshake();
        for (int cyc = 1; cyc <= 3; cyc++) begin
            checks++;
            if ({sample_en, sar_start, out_valid} !== {cyc <= 2, cyc == 3, 1'b0}) begin
                errors++;
                $display("FAIL cont_restart cycle h+%0d en/start/valid got %b exp %b", cyc,
                         {sample_en, sar_start, out_valid}, {cyc <= 2, cyc == 3, 1'b0});
            end
            if (cyc < 3) step();
        end
        convert(4'd9, 2);
        checks++;
        if (out_valid !== 1'b1 || result !== 4'd9) begin
            errors++;
            $display("FAIL cont_second valid=%b result=%0d exp 1 9", out_valid, result);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({sample_en, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL ready_early_1 en/valid got %b exp 10", {sample_en, out_valid});
        end
        wait_sar_start(got);
        convert(4'd2, 1);
        checks++;
        if (!got || out_valid !== 1'b1 || result !== 4'd2) begin
            errors++;
            $display("FAIL ready_early_2 got=%0d valid=%b result=%0d exp 1 1 2", got, out_valid, result);
        end
        step();
        checks++;
        if ({sample_en, out_valid, busy} !== 3'b101) begin
            errors++;
            $display("FAIL ready_early_3 en/valid/busy got %b exp 101", {sample_en, out_valid, busy});
        end
        out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_timeout();
        bit got; bit seen_valid;
        seen_valid = 1'b0;
        drive_start(4'd0, 2'd0, 1'b0);
        wait_sar_start(got);
        for (int j = 1; j <= 31; j++) begin
            step();
            seen_valid |= out_valid;
        end
        checks++;
        if (!got || {busy, err} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_early got=%0d busy/err got %b exp 10", got, {busy, err});
        end
        step();
        seen_valid |= out_valid;
        step();
        seen_valid |= out_valid;
        checks++;
        if ({busy, err, seen_valid} !== 3'b010) begin
            errors++;
            $display("FAIL timeout_abort busy/err/seen_valid got %b exp 010", {busy, err, seen_valid});
        end
        drive_start(4'd0, 2'd0, 1'b0);
        checks++;
        if ({busy, err} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_clear busy/err got %b exp 10", {busy, err});
        end
        wait_sar_start(got);
        convert(4'd3, 1);
        checks++;
        if (!got || out_valid !== 1'b1 || result !== 4'd3) begin
            errors++;
            $display("FAIL timeout_recover got=%0d valid=%b result=%0d exp 1 1 3", got, out_valid, result);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        bit got; int p; bit ok;
        drive_start(4'd1, 2'd0, 1'b0);
        wait_sar_start(got);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!got || {sample_en, sar_start, out_valid, busy, err, result} !== 9'b0) begin
            errors++;
            $display("FAIL reset_async got=%0d outputs %b exp 000000000", got, {sample_en, sar_start, out_valid, busy, err, result});
        end
        step();
        rst_n = 1'b1;
        step();
        sar_done = 1'b1;
        sar_code = 4'd5;
        step();
        sar_done = 1'b0;
        step();
        checks++;
        if ({sample_en, sar_start, out_valid, busy, err, result} !== 9'b0) begin
            errors++;
            $display("FAIL stray_done outputs %b exp 000000000", {sample_en, sar_start, out_valid, busy, err, result});
        end
        run_samples(4'd0, 2'd0, 1'b0, 1, 32'h0000_0006, 2, p, ok);
        checks++;
        if (!ok || out_valid !== 1'b1 || result !== 4'd6) begin
            errors++;
            $display("FAIL reset_rerun ok=%0d valid=%b result=%0d exp 1 1 6", ok, out_valid, result);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_single();
        test_averaging();
        test_clamp_round();
        test_backpressure_cont();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/sar_conv_sequencer.md
# sar_conv_sequencer

Conversion sequencer for the 4-bit SAR ADC logic. It owns the ADC's track/hold and start timing, and runs single-shot or continuous conversions. It can oversample with power-of-two averaging, and delivers each result over a valid/ready handshake. It sits between the top-level pin wrapper (configuration and result pins) and the SAR logic block.

## Interface
Parameters:
- N_BITS, 4, SAR code width
- MAX_AVG_LOG2, 3, largest supported avg_log2 (up to 8 samples averaged)
- TIMEOUT_CYCLES, 32, max cycles from sar_start to sar_done before abort

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- cont_mode  in  1  1 = restart automatically after each handshake
- sample_cycles  in  4  track time minus one (0 → 1 cycle)
- avg_log2  in  2  samples per result = 2^avg_log2; values > MAX_AVG_LOG2 clamp to MAX_AVG_LOG2
- sample_en  out  1  track/hold control to the analog front end; 1 = track
- sar_start  out  1  one-cycle pulse that begins a SAR conversion
- sar_done  in  1  SAR conversion complete; sampled only in CONVERT
- sar_code  in  N_BITS  SAR result, valid when sar_done = 1
- result  out  N_BITS  averaged code; stable while out_valid = 1
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- busy  out  1  state ≠ IDLE
- err  out  1  sticky timeout flag; cleared when the next start is accepted

## Operation
- States are IDLE, SAMPLE, CONVERT, OUTPUT.
- IDLE:
  - On start = 1, latch cont_mode, sample_cycles and avg_log2 (clamped) into shadow registers.
  - Clear the accumulator, the sample counter and err; go to SAMPLE.
- SAMPLE:
  - sample_en = 1 for exactly latched sample_cycles + 1 cycles, then go to CONVERT.
- CONVERT:
  - sar_start = 1 in the first CONVERT cycle only; sample_en = 0.
  - From the second CONVERT cycle on, sar_done = 1 adds sar_code to the accumulator (width N_BITS + MAX_AVG_LOG2) and increments the sample counter.
  - If fewer than 2^avg_log2 samples are taken, go back to SAMPLE.
  - Otherwise register result and go to OUTPUT.
  - Result arithmetic, with sum including the current sample:
    - avg_log2 = 0: result = sum.
    - avg_log2 > 0: result = (sum + 2^(avg_log2-1)) >> avg_log2 (round half up).
    - This never exceeds 2^N_BITS - 1, so no saturation is needed.
  - A cycle counter runs from sar_start. If it reaches TIMEOUT_CYCLES with no sar_done: set err = 1, discard the accumulator, go to IDLE. No out_valid is produced.
- OUTPUT:
  - out_valid = 1; result is held.
  - On out_valid & out_ready, the handshake completes.
  - If latched cont_mode = 1: clear the accumulator and counter and go to SAMPLE. The shadow config is kept; new config pins take effect only on a fresh start from IDLE.
  - Else go to IDLE.
- start outside IDLE is ignored. Continuous mode is stopped only by reset.
- sar_done outside CONVERT, or in the sar_start cycle, is ignored.

## Timing
- Reset (async assert, sync release):
  - state = IDLE.
  - sample_en = 0, sar_start = 0, out_valid = 0, busy = 0, err = 0.
  - result = 0, accumulator and counters = 0.
- All outputs are registered; none has a combinational path from an input.
- Reference sequence, with start high at cycle 0 in IDLE:
  - Cycles 1..S+1: SAMPLE.
  - Cycle S+2: CONVERT with sar_start = 1.
  - sar_done at cycle S+2+k (k ≥ 1): out_valid = 1 at cycle S+3+k when averaging 1 sample.
- Each additional sample adds S+2+k cycles.
- Continuous mode: the handshake cycle h is followed by SAMPLE at h+1.
- out_ready may be held high before out_valid. The result is then consumed in the first out_valid cycle.
- Reset asserted mid-operation returns immediately to reset values. A SAR conversion in flight is abandoned, and any late sar_done is ignored (the sequencer is in IDLE).
- busy = 1 from the cycle after start is accepted until the cycle after returning to IDLE.

## Test plan
- Single shot:
  - Stimulus: sample_cycles = 2, avg_log2 = 0; SAR model returns 0xA with k = 4.
  - Response: sample_en high at cycles 1–3; sar_start at cycle 4; out_valid at cycle 9 with result = 0xA; IDLE after out_ready.
- Averaging:
  - Stimulus: avg_log2 = 2; codes 3, 4, 4, 4 (sum 15).
  - Response: exactly 4 sar_start pulses; result = (15+2)>>2 = 4. Codes 15 ×4 → result = 15.
- Clamp and rounding:
  - Stimulus: avg_log2 = 3 with codes 1,1,1,1,1,1,1,2 (sum 9).
  - Response: result = (9+4)>>3 = 1.
- Backpressure and continuous mode:
  - Stimulus: cont_mode = 1; out_ready low for 10 cycles, then toggled.
  - Response: result stable, no new sar_start while out_valid = 1; next SAMPLE begins the cycle after each handshake; config changes mid-run have no effect.
- Timeout:
  - Stimulus: SAR model never asserts sar_done.
  - Response: after TIMEOUT_CYCLES, err = 1, busy falls, out_valid never rises; the next start clears err.
- Reset mid-conversion:
  - Stimulus: rst_n low during CONVERT, released, then a stray sar_done.
  - Response: all outputs at reset values; no result produced; a subsequent start runs normally.
